// File: rtl/adder_pkg.sv
// Shared definitions for the ripple-carry adder datapath: FSM state encoding
// and the default operand width.
package adder_pkg;

    localparam int DEFAULT_SIZE = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/rca_cout_chain.sv
// SIZE-bit ripple chain of full adders with carry-in tied low and the final
// carry exposed. Purely combinational.
module rca_cout_chain #(
    parameter int SIZE = 4
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic [SIZE-1:0] sum,
    output logic            cout
);

    logic [SIZE:0] carry;

    assign carry[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < SIZE; gi++) begin : g_fa
            assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[SIZE];

endmodule

// File: rtl/rca_burst_accumulator.sv
// Sums BURST handshaked operands through a ripple-carry chain and presents the
// sum plus a sticky carry flag downstream. Define ADDER_SAT_EN to saturate.
module rca_burst_accumulator
    import adder_pkg::*;
#(
    parameter int SIZE  = DEFAULT_SIZE,
    parameter int BURST = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] out_sum,
    output logic            out_carry
);

    localparam int CNT_W = $clog2(BURST + 1);

    state_t           state_reg, state_next;
    logic [SIZE-1:0]  acc_reg, acc_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             ovf_reg, ovf_next;

    logic [SIZE-1:0]  add_sum;
    logic [SIZE-1:0]  add_res;
    logic             add_cout;
    logic             accept;
    logic             transfer;
    logic             last_op;

    rca_cout_chain #(.SIZE(SIZE)) u_chain (
        .a    (acc_reg),
        .b    (in_data),
        .sum  (add_sum),
        .cout (add_cout)
    );

`ifdef ADDER_SAT_EN
    // Once pinned at all-ones any further nonzero operand carries out again,
    // so the accumulator stays saturated for the rest of the burst.
    assign add_res = add_cout ? {SIZE{1'b1}} : add_sum;
`else
    assign add_res = add_sum;
`endif

    assign in_ready  = (state_reg != HOLD);
    assign out_valid = (state_reg == HOLD);
    assign out_sum   = out_valid ? acc_reg : '0;
    assign out_carry = out_valid & ovf_reg;

    assign accept   = in_valid && in_ready;
    assign transfer = out_valid && out_ready;
    assign last_op  = ((cnt_reg + CNT_W'(1)) == CNT_W'(BURST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            ovf_reg   <= ovf_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        ovf_next   = ovf_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    acc_next   = in_data;
                    ovf_next   = 1'b0;
                    cnt_next   = CNT_W'(1);
                    state_next = (BURST == 1) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_next = add_res;
                    ovf_next = ovf_reg | add_cout;
                    cnt_next = cnt_reg + CNT_W'(1);
                    if (last_op) begin
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (transfer) begin
                    state_next = IDLE;
                    acc_next   = '0;
                    cnt_next   = '0;
                    ovf_next   = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
                acc_next   = '0;
                cnt_next   = '0;
                ovf_next   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rca_burst_accumulator.sv
// Bench for rca_burst_accumulator: BURST=4 and BURST=1 instances against a
// sum-of-operands model. Honour ADDER_SAT_EN when compiling both together.
module tb_rca_burst_accumulator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid  [2];
    logic       in_ready  [2];
    logic [3:0] in_data   [2];
    logic       out_valid [2];
    logic       out_ready [2];
    logic [3:0] out_sum   [2];
    logic       out_carry [2];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Behavioural model: per instance, the running integer total of the burst.
    int   m_burst [2] = '{4, 1};
    int   m_cnt   [2] = '{0, 0};
    int   m_total [2] = '{0, 0};
    bit   m_hold  [2] = '{0, 0};
    int   m_sum   [2] = '{0, 0};
    bit   m_carry [2] = '{0, 0};
    logic [4:0] res0 [$];
    logic [4:0] res1 [$];
    bit   rand_on = 0;

    always #5 clk = ~clk;

    rca_burst_accumulator #(.SIZE(4), .BURST(4)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_sum(out_sum[0]), .out_carry(out_carry[0])
    );

    rca_burst_accumulator #(.SIZE(4), .BURST(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_sum(out_sum[1]), .out_carry(out_carry[1])
    );

    function automatic int exp_sum_of(input int total);
`ifdef ADDER_SAT_EN
        return (total > 15) ? 15 : total;
`else
        return total % 16;
`endif
    endfunction

    // Inputs change only at posedge+1, so the negedge sees what the next edge samples.
    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            bit       e_rdy, e_vld;
            logic [3:0] e_sum;
            bit       e_car;
            e_rdy = rst ? 1'b1 : !m_hold[k];
            e_vld = rst ? 1'b0 : m_hold[k];
            e_sum = (rst || !m_hold[k]) ? 4'd0 : 4'(m_sum[k]);
            e_car = (rst || !m_hold[k]) ? 1'b0 : m_carry[k];
            checks++;
            if (in_ready[k] !== e_rdy || out_valid[k] !== e_vld ||
                ((rst || m_hold[k]) && (out_sum[k] !== e_sum || out_carry[k] !== e_car))) begin
                failures++;
                $display("FAIL cycle_check dut%0d cyc=%0d got rdy=%b vld=%b sum=%0d car=%b want rdy=%b vld=%b sum=%0d car=%b",
                         k, cyc, in_ready[k], out_valid[k], out_sum[k], out_carry[k],
                         e_rdy, e_vld, e_sum, e_car);
            end
            if (rst) begin
                m_cnt[k] = 0; m_total[k] = 0; m_hold[k] = 0;
            end else if (m_hold[k]) begin
                if (out_ready[k]) begin
                    if (k == 0) res0.push_back({out_carry[k], out_sum[k]});
                    else        res1.push_back({out_carry[k], out_sum[k]});
                    $display("dut%0d result sum=%0d carry=%b", k, out_sum[k], out_carry[k]);
                    m_hold[k] = 0; m_cnt[k] = 0; m_total[k] = 0;
                end
            end else if (in_valid[k]) begin
                m_total[k] += int'(in_data[k]);
                m_cnt[k]++;
                if (m_cnt[k] == m_burst[k]) begin
                    m_hold[k]  = 1;
                    m_sum[k]   = exp_sum_of(m_total[k]);
                    m_carry[k] = (m_total[k] > 15);
                end
            end
        end
    end

    task automatic drive_op(input int k, input logic [3:0] d);
        bit acc, rdy;
        int n;
        acc = 0; n = 0;
        in_valid[k] = 1'b1;
        in_data[k]  = d;
        while (!acc && n < 200) begin
            @(negedge clk);
            rdy = in_ready[k];
            @(posedge clk);
            #1;
            acc = rdy;
            n++;
        end
        in_valid[k] = 1'b0;
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL accept_timeout dut%0d data=%0d got no accept want accept", k, d);
        end
    endtask

    task automatic check_res(input int k, input int es, input bit ec, input string nm);
        logic [4:0] r;
        checks++;
        if ((k == 0 && res0.size() == 0) || (k == 1 && res1.size() == 0)) begin
            failures++;
            $display("FAIL %s dut%0d got no result want sum=%0d carry=%b", nm, k, es, ec);
        end else begin
            r = (k == 0) ? res0.pop_front() : res1.pop_front();
            if (r[3:0] !== 4'(es) || r[4] !== ec) begin
                failures++;
                $display("FAIL %s dut%0d got sum=%0d carry=%b want sum=%0d carry=%b",
                         nm, k, r[3:0], r[4], es, ec);
            end
        end
    endtask

    task automatic check_bit(input string nm, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got %b want %b", nm, got, want);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ready(input int k);
        while (rand_on) begin
            @(posedge clk);
            #1;
            out_ready[k] = 1'($urandom_range(0, 1));
        end
        out_ready[k] = 1'b1;
    endtask

    task automatic rand_bursts(input int k, input int nops);
        for (int i = 0; i < nops; i++) begin
            drive_op(k, 4'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 2)) next_cycle();
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            in_valid[k] = 1'b0; in_data[k] = 4'd0; out_ready[k] = 1'b1;
        end
        repeat (2) next_cycle();
        check_bit("reset_in_ready", in_ready[0], 1'b1);
        check_bit("reset_out_valid", out_valid[0], 1'b0);
        rst = 1'b0;
        next_cycle();

        // 1: back-to-back 1,2,3,4
        drive_op(0, 4'd1); drive_op(0, 4'd2); drive_op(0, 4'd3); drive_op(0, 4'd4);
        check_bit("t1_latency_out_valid", out_valid[0], 1'b1);
        next_cycle();
        check_res(0, 10, 1'b0, "t1_sum");
        check_bit("t1_back_idle", in_ready[0], 1'b1);

        // 2: overflow 15,1,0,0
        drive_op(0, 4'd15); drive_op(0, 4'd1); drive_op(0, 4'd0); drive_op(0, 4'd0);
        next_cycle();
`ifdef ADDER_SAT_EN
        check_res(0, 15, 1'b1, "t2_sat");
`else
        check_res(0, 0, 1'b1, "t2_wrap");
`endif

        // 3: backpressure with upstream still presenting 7
        out_ready[0] = 1'b0;
        drive_op(0, 4'd2); drive_op(0, 4'd2); drive_op(0, 4'd2); drive_op(0, 4'd2);
        in_valid[0] = 1'b1; in_data[0] = 4'd7;
        repeat (5) next_cycle();
        check_bit("t3_held_valid", out_valid[0], 1'b1);
        check_bit("t3_held_in_ready", in_ready[0], 1'b0);
        checks++;
        if (out_sum[0] !== 4'd8) begin
            failures++;
            $display("FAIL t3_held_sum got %0d want 8", out_sum[0]);
        end
        in_valid[0] = 1'b0; out_ready[0] = 1'b1;
        next_cycle();
        check_res(0, 8, 1'b0, "t3_sum");
        drive_op(0, 4'd1); drive_op(0, 4'd1); drive_op(0, 4'd1); drive_op(0, 4'd1);
        next_cycle();
        check_res(0, 4, 1'b0, "t3_next_burst");

        // 4: gaps between 3,0,4,1
        drive_op(0, 4'd3); repeat (1) next_cycle();
        drive_op(0, 4'd0); repeat (3) next_cycle();
        drive_op(0, 4'd4); repeat (2) next_cycle();
        drive_op(0, 4'd1);
        next_cycle();
        check_res(0, 8, 1'b0, "t4_gaps");

        // 5: async reset mid-burst
        drive_op(0, 4'd5); drive_op(0, 4'd5);
        #2 rst = 1'b1;
        #1;
        check_bit("t5_rst_in_ready", in_ready[0], 1'b1);
        check_bit("t5_rst_out_valid", out_valid[0], 1'b0);
        next_cycle();
        rst = 1'b0;
        next_cycle();
        drive_op(0, 4'd5); drive_op(0, 4'd5); drive_op(0, 4'd5); drive_op(0, 4'd5);
        next_cycle();
`ifdef ADDER_SAT_EN
        check_res(0, 15, 1'b1, "t5_sat");
`else
        check_res(0, 4, 1'b1, "t5_wrap");
`endif

        // 6: BURST=1 instance
        drive_op(1, 4'd9);
        check_bit("t6_hold_valid", out_valid[1], 1'b1);
        check_bit("t6_hold_in_ready", in_ready[1], 1'b0);
        drive_op(1, 4'd6);
        check_bit("t6_hold2_in_ready", in_ready[1], 1'b0);
        next_cycle();
        check_res(1, 9, 1'b0, "t6_first");
        check_res(1, 6, 1'b0, "t6_second");

        // Random phase: per-cycle compare carries the checking.
        rand_on = 1;
        fork
            rand_ready(0);
            rand_ready(1);
            begin
                fork
                    rand_bursts(0, 160);
                    rand_bursts(1, 60);
                join
                rand_on = 0;
            end
        join
        repeat (8) next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
